butterfly_p2s: RTL

Parallel-to-serial de-skew stage placed directly downstream of the butterfly serial-to-parallel converter and its lane-parallel datapath. It accepts one `num_input`-lane word per handshake and emits the lanes one sample per beat. Lane selection applies the inverse of the converter's skew, so the serial output stream returns to natural sample order. Unlike the converter, it exerts real backpressure in both directions through a 2-entry input buffer and a registered output stage.

---
 rtl/butterfly_pkg.sv | 19 +
 rtl/butterfly_p2s_if.sv | 28 ++
 rtl/butterfly_p2s_buf.sv | 66 ++++++
 rtl/butterfly_p2s.sv | 103 ++++++++++
 4 files changed

// File: rtl/butterfly_pkg.sv
// Shared definitions for the butterfly converter pair (skew span, length width, popcount).
// Latency: none, constants and a pure function.
// Backpressure: not applicable.
package butterfly_pkg;

    localparam int BFLY_SKEW_BITS = 8;
    localparam int BFLY_LEN_W     = 16;

    // Number of set bits in an 8-bit slice; the converter derives its lane skew from the same count.
    function automatic logic [3:0] bfly_popcount8(input logic [BFLY_SKEW_BITS-1:0] v);
        logic [3:0] n;
        n = '0;
        for (int i = 0; i < BFLY_SKEW_BITS; i++) begin
            n = n + {3'b000, v[i]};
        end
        return n;
    endfunction

endpackage

// File: rtl/butterfly_p2s_if.sv
// Upstream word handshake plus downstream serial handshake of the p2s stage.
// Latency: none, wiring only.
// Backpressure: up_rdy flows from the stage to the source, dn_rdy from the sink to the stage.
interface butterfly_p2s_if #(
    parameter int data_width = 16,
    parameter int num_input  = 8
);
    import butterfly_pkg::*;

    logic [num_input*data_width-1:0] up_dat;
    logic                            up_vld;
    logic                            up_rdy;
    logic [BFLY_LEN_W-1:0]           length;
    logic [data_width-1:0]           dn_dat;
    logic                            dn_vld;
    logic                            dn_rdy;

    modport master (
        output up_dat, up_vld, length, dn_rdy,
        input  up_rdy, dn_dat, dn_vld
    );

    modport slave (
        input  up_dat, up_vld, length, dn_rdy,
        output up_rdy, dn_dat, dn_vld
    );

endinterface

// File: rtl/butterfly_p2s_buf.sv
// Two-entry word FIFO holding parallel words until their last lane has been serialized.
// Latency: a pushed word is visible on head the cycle after the push edge.
// Backpressure: not_full is registered from the post-edge occupancy, so it never depends on push or pop combinationally.
module butterfly_p2s_buf #(
    parameter int width = 128
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic [width-1:0] push_dat,
    input  logic             push_vld,
    output logic             not_full,
    input  logic             pop,
    output logic [width-1:0] head,
    output logic             empty
);

    logic [width-1:0] mem [2];
    logic             wr_ptr;
    logic             rd_ptr;
    logic [1:0]       count;
    logic [1:0]       count_next;
    logic             push;
    logic             do_pop;

    assign push   = push_vld && not_full;
    assign do_pop = pop && (count != 2'd0);
    assign head   = mem[rd_ptr];
    assign empty  = (count == 2'd0);

    // Occupancy after this edge; a simultaneous push and pop leaves it unchanged.
    always_comb begin
        count_next = count;
        if (push && !do_pop) begin
            count_next = count + 2'd1;
        end else if (!push && do_pop) begin
            count_next = count - 2'd1;
        end
    end

    // Word storage; contents are only meaningful while counted as occupied.
    always_ff @(posedge clk) begin
        if (push) begin
            mem[wr_ptr] <= push_dat;
        end
    end

    // Pointers, occupancy and the registered ready flag; ready stays low through reset.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_ptr   <= 1'b0;
            rd_ptr   <= 1'b0;
            count    <= 2'd0;
            not_full <= 1'b0;
        end else begin
            if (push) begin
                wr_ptr <= ~wr_ptr;
            end
            if (do_pop) begin
                rd_ptr <= ~rd_ptr;
            end
            count    <= count_next;
            not_full <= (count_next <= 2'd1);
        end
    end

endmodule

// File: rtl/butterfly_p2s.sv
// Parallel-to-serial de-skew: emits each buffered word one lane per beat in natural sample order (skew via BUTTERFLY_P2S_SKEW_EN).
// Latency: word accepted at edge T gives its first beat on dn_dat after edge T+1.
// Backpressure: 2-word buffer with registered up_rdy; the output register holds while dn_vld && !dn_rdy.
module butterfly_p2s
    import butterfly_pkg::*;
#(
    parameter int data_width = 16,
    parameter int num_input  = 8
) (
    input  logic           clk,
    input  logic           rst_n,
    butterfly_p2s_if.slave bus
);

    localparam int                    NB      = $clog2(num_input);
    localparam int                    WORD_W  = num_input * data_width;
    localparam logic [BFLY_LEN_W-1:0] MIN_LEN = BFLY_LEN_W'(num_input);

    logic [WORD_W-1:0]     head;
    logic                  buf_empty;
    logic                  load;
    logic                  pop;
    logic                  wrap;
    logic [BFLY_LEN_W-1:0] cnt;
    logic [BFLY_LEN_W-1:0] length_r;
    logic [BFLY_LEN_W-1:0] len_cur;
    logic [BFLY_LEN_W-1:0] len_eff;
    logic [NB-1:0]         sel;
    logic [data_width-1:0] lane;
    logic [data_width-1:0] dn_dat_q;
    logic                  dn_vld_q;

    butterfly_p2s_buf #(
        .width (WORD_W)
    ) u_buf (
        .clk      (clk),
        .rst_n    (rst_n),
        .push_dat (bus.up_dat),
        .push_vld (bus.up_vld),
        .not_full (bus.up_rdy),
        .pop      (pop),
        .head     (head),
        .empty    (buf_empty)
    );

    assign bus.dn_dat = dn_dat_q;
    assign bus.dn_vld = dn_vld_q;

    // A beat is loaded whenever a word is waiting and the output register is free or draining.
    assign load = !buf_empty && (!dn_vld_q || bus.dn_rdy);

    // Frame length in force for this beat (fresh from the input on the first beat) and the wrap/pop decision.
    always_comb begin
        len_cur = (cnt == '0) ? bus.length : length_r;
        len_eff = (len_cur < MIN_LEN) ? MIN_LEN : len_cur;
        wrap    = (cnt == (len_eff - BFLY_LEN_W'(1)));
        pop     = load && ((&cnt[NB-1:0]) || wrap);
    end

`ifdef BUTTERFLY_P2S_SKEW_EN
    logic [3:0] skew;

    // Undo the converter's rotation: lane = low count bits plus popcount of the next eight bits, modulo lanes.
    always_comb begin
        skew = bfly_popcount8(cnt[NB +: BFLY_SKEW_BITS]);
        sel  = cnt[NB-1:0] + NB'(skew);
    end
`else
    // Plain in-order serialization.
    always_comb begin
        sel = cnt[NB-1:0];
    end
`endif

    assign lane = head[data_width*sel +: data_width];

    // Beat counter and frame length latch; any partial frame is abandoned on reset.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cnt      <= '0;
            length_r <= '0;
        end else if (load) begin
            cnt <= wrap ? '0 : cnt + BFLY_LEN_W'(1);
            if (cnt == '0) begin
                length_r <= bus.length;
            end
        end
    end

    // Output register: load the selected lane, drop valid once consumed with nothing behind it, else hold.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            dn_dat_q <= '0;
            dn_vld_q <= 1'b0;
        end else if (load) begin
            dn_dat_q <= lane;
            dn_vld_q <= 1'b1;
        end else if (bus.dn_rdy) begin
            dn_vld_q <= 1'b0;
        end
    end

endmodule
